// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential compare unit:
//   - op encodings seen on the op port (3 bits; 6 and 7 are reserved)
//   - FSM state encoding
//   - is_signed(): true for the two's-complement modes
//   - select_result(): maps the recorded lt/eq flags to the 1-bit result
// -----------------------------------------------------------------------------
package cmp_pkg;

  localparam logic [2:0] OP_SLTU = 3'd0;
  localparam logic [2:0] OP_SLT  = 3'd1;
  localparam logic [2:0] OP_SEQ  = 3'd2;
  localparam logic [2:0] OP_SNE  = 3'd3;
  localparam logic [2:0] OP_SGEU = 3'd4;
  localparam logic [2:0] OP_SGE  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_SLT) || (op == OP_SGE);
  endfunction

  // Reserved codes produce 0 but still run through the normal timing.
  function automatic logic select_result(input logic [2:0] op,
                                         input logic       lt,
                                         input logic       eq);
    logic r;
    case (op)
      OP_SLTU, OP_SLT: r = lt;
      OP_SEQ:          r = eq;
      OP_SNE:          r = !eq;
      OP_SGEU, OP_SGE: r = !lt;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// -----------------------------------------------------------------------------
// cmp_chunk
// Combinational unsigned compare of one CHUNK-bit slice.
//   a_i, b_i      : operand slices
//   invert_msb_i  : flip the MSB of both slices first (two's-complement
//                   ordering for the most-significant slice of a signed op)
//   lt_o          : a < b after the optional MSB flip
//   eq_o          : a == b
// -----------------------------------------------------------------------------
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             invert_msb_i,
  output logic             lt_o,
  output logic             eq_o
);

  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  always_comb begin
    a_m            = a_i;
    b_m            = b_i;
    a_m[CHUNK-1]   = a_i[CHUNK-1] ^ invert_msb_i;
    b_m[CHUNK-1]   = b_i[CHUNK-1] ^ invert_msb_i;
  end

  // Flipping the same bit on both sides never changes equality.
  assign lt_o = (a_m < b_m);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/seq_compare_unit.sv
// -----------------------------------------------------------------------------
// seq_compare_unit
// Multi-cycle comparator: walks the operands CHUNK bits per cycle from the
// most-significant slice down and stops at the first slice that differs.
// WIDTH must be a multiple of CHUNK.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : request present          in_ready  : request can be taken
//   A, B       : operands                 op        : compare mode (cmp_pkg)
//   out_valid  : result present           out_ready : consumer takes result
//   res        : 0/1 result zero-extended to WIDTH
//   busy       : high while comparing or holding a result
// -----------------------------------------------------------------------------
module seq_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               res_q, res_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic               chunk_lt;
  logic               chunk_eq;

  // Only the top slice of a signed compare carries the sign bit.
  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i          (a_chunk),
    .b_i          (b_chunk),
    .invert_msb_i (is_signed(op_q) && (idx_q == IDX_LAST)),
    .lt_o         (chunk_lt),
    .eq_o         (chunk_eq)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = WIDTH'(res_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          idx_d   = IDX_LAST;
          state_d = CMP;
        end
      end
      CMP: begin
        // A differing slice decides the outcome; equal all the way down means
        // lt=0/eq=1, which is exactly what the last slice reports.
        if (!chunk_eq || (idx_q == '0)) begin
          res_d   = select_result(op_q, chunk_lt, chunk_eq);
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // NOTE: the operand/op holding registers are deliberately left without
  // reset; they are only read in CMP, which is reached solely by a fresh load.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

endmodule

// File: tb/tb_seq_compare_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_compare_unit
// Directed bench for seq_compare_unit (WIDTH=32, CHUNK=8). The stimulus
// process pushes the hand-computed result and latency for each request into
// a scoreboard queue; a monitor pops and compares each time out_valid rises.
// -----------------------------------------------------------------------------
module tb_seq_compare_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

  localparam logic [2:0] SLTU = 3'd0;
  localparam logic [2:0] SLT  = 3'd1;
  localparam logic [2:0] SEQ  = 3'd2;
  localparam logic [2:0] SNE  = 3'd3;
  localparam logic [2:0] SGEU = 3'd4;
  localparam logic [2:0] SGE  = 3'd5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             busy;

  seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------- monitor
  int   cyc        = 0;
  int   accept_cyc = 0;
  logic ov_prev    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    // An accept seen here completes on the coming rising edge.
    if (in_valid && in_ready) accept_cyc = cyc + 1;
    if (out_valid && !ov_prev) begin
      if (sb_q.size() == 0) begin
        check("stale_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("res", res, e.res);
        check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
      end
    end
    ov_prev = out_valid;
  end

  // -------------------------------------------------------------- stimulus
  // All drives happen 1 time unit after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    int n = 0;
    A = a; B = b; op = o; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not affect the result.
    in_valid = 1'b0;
    A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A; op = SEQ;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input int el);
    int n = 0;
    exp_t e;
    e.res = er; e.lat = el;
    sb_q.push_back(e);
    issue(o, a, b);
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready) && n < 40);
    if (!(out_valid && out_ready)) check("done_timeout", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; op = SLTU;

    // Reset state, with a request presented during reset (must be ignored).
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_req_dropped", 32'(busy), 32'd0);

    // Directed vectors: op, A, B, expected res, expected latency.
    run_op(SLTU,  32'h0000_0001, 32'h0000_0002, 32'd1, 4);
    run_op(SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1);
    run_op(SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1);
    run_op(SEQ,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 4);
    run_op(SNE,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 4);
    run_op(SGE,   32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1);
    run_op(SGEU,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1);
    run_op(3'd7,  32'h1200_0000, 32'h3400_0000, 32'd0, 1);
    run_op(SLT,   32'h0102_0304, 32'h0103_0000, 32'd1, 2);
    run_op(SNE,   32'h1122_3344, 32'h1122_3345, 32'd1, 4);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    begin
      exp_t e;
      e.res = 32'd1; e.lat = 4;
      sb_q.push_back(e);
    end
    issue(SGEU, 32'h0000_0005, 32'h0000_0003);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_res", res, 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_res_kept", res, 32'd1);

    // Reset on the 2nd CMP cycle of an equal-operand SEQ: result discarded.
    A = 32'h1357_2468; B = 32'h1357_2468; op = SEQ; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", res, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;

    // Recovery after reset.
    run_op(SLT,   32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_compare_unit.md
Name: seq_compare_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle unsigned set-less-than in the arithmetic/logical group.
- Compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first, and stops at the first differing chunk.
- Supports signed and unsigned less-than, equality and greater-or-equal modes.
- Sits behind the ALU op decoder; valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 32: operand and result width.
- CHUNK, 8: bits compared per cycle. WIDTH must be a multiple of CHUNK; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- op  input  3  mode: 0 SLTU, 1 SLT, 2 SEQ, 3 SNE, 4 SGEU, 5 SGE, 6/7 reserved
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- res  output  WIDTH  result, value 0 or 1 zero-extended to WIDTH
- busy  output  1  high in CMP or DONE

Behaviour:
- Reset (synchronous, active-high; the edge with rst=1 is the reset):
  - state goes to IDLE; out_valid=0; res=0; busy=0.
  - Latched operands, op and chunk index are discarded.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B, op; set idx=NCHUNK-1; go to CMP.
- CMP, one chunk per cycle:
  - Compare a=A[idx*CHUNK +: CHUNK] against b=B[idx*CHUNK +: CHUNK], unsigned.
  - For signed ops (SLT, SGE) and idx==NCHUNK-1, invert the MSB of both chunks before comparing. This gives two's-complement ordering.
  - If a!=b: record lt=(a<b), eq=0; go to DONE.
  - Else if idx==0: record lt=0, eq=1; go to DONE.
  - Else idx<=idx-1 and stay in CMP.
- Result, registered on the CMP->DONE transition:
  - SLTU/SLT: lt.
  - SEQ: eq.
  - SNE: !eq.
  - SGEU/SGE: !lt.
  - Reserved op codes: 0, with normal timing.
  - Upper WIDTH-1 bits of res are always 0.
- Latency:
  - out_valid rises m cycles after the accept edge, where m = number of chunks examined, 1..NCHUNK.
  - Equal operands always take NCHUNK cycles.
- DONE:
  - out_valid=1; in_ready=0.
  - res is stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid=0 next cycle. res holds its value until the next result.
- Throughput:
  - No new request is accepted until the cycle after the output handshake.
  - Maximum one result per m+2 cycles.
- Input changes on A, B or op after acceptance have no effect.
- Reset mid-operation (rst high in CMP or DONE): follows the reset rules above; the pending result is lost and never presented.
- rst and in_valid high together: the request is not accepted.

Decomposition:
- Package cmp_pkg holds:
  - op encoding constants (OP_SLTU=3'd0 … OP_SGE=3'd5);
  - the state encoding (IDLE, CMP, DONE);
  - a helper function is_signed(op).
- One sub-module, cmp_chunk: combinational CHUNK-bit compare with an invert_msb input; outputs lt and eq. It is instantiated once and driven by a mux on idx.
- Top module holds the FSM, operand registers, index counter and result register.

Test Plan (WIDTH=32, CHUNK=8):
- SLTU, A=0x00000001, B=0x00000002 -> out_valid 4 cycles after accept, res=0x00000001.
- SLT, A=0xFFFFFFFF, B=0x00000001 -> res=1 after 1 cycle. SLTU with the same operands -> res=0 after 1 cycle.
- SEQ, A=B=0xDEADBEEF -> res=1 after 4 cycles. SNE with the same operands -> res=0 after 4 cycles.
- SGE, A=0x80000000, B=0x7FFFFFFF -> res=0. SGEU with the same operands -> res=1. op=7 -> res=0 with full handshake.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, res stable, in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Reset mid-CMP: SEQ with equal operands, pulse rst on the 2nd CMP cycle -> next cycle out_valid=0, res=0, busy=0. in_ready=1 once rst is low; no stale result appears.
